uoram_multi_frontend: RTL

Parametrised successor to the unified-ORAM frontend command path. It arbitrates program requests from `NumChannels` independent ports and walks the PosMap recursion chain through an external PLB lookup handshake. It issues the resulting backend command sequence from the deepest PosMap block down to the data block. Out-of-range addresses are reported on an error channel instead of halting simulation. The block sits between the network-side request ports and the Path ORAM backend command port; the data path is outside its scope.

---
 rtl/uoram_pkg.sv | 29 ++
 rtl/uoram_rr_arbiter.sv | 46 ++++
 rtl/uoram_multi_frontend.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/uoram_pkg.sv
// Shared backend command encodings, frontend FSM state type and width helpers
// for the unified-ORAM frontend blocks.
package uoram_pkg;

  localparam logic [1:0] BECMD_Update  = 2'd0;
  localparam logic [1:0] BECMD_Read    = 2'd1;
  localparam logic [1:0] BECMD_ReadRmv = 2'd2;
  localparam logic [1:0] BECMD_Append  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WAIT,
    ST_ISSUE
  } fe_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

  // Index width that never collapses to zero bits (single channel / single level).
  function automatic int idx_width(input int v);
    return (clog2(v) > 0) ? clog2(v) : 1;
  endfunction

endpackage

// File: rtl/uoram_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; on Advance the pointer moves just past the granted index.
module uoram_rr_arbiter
  import uoram_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [N-1:0]            Request,
  input  logic                    Advance,
  output logic [N-1:0]            Grant,
  output logic [idx_width(N)-1:0] GrantIdx
);

  localparam int IW = idx_width(N);

  logic [IW-1:0]  ptr;
  logic [2*N-1:0] rot;
  logic [IW:0]    sum;

  // Scan from the highest offset down so the offset closest to the pointer wins.
  always_comb begin
    rot      = {Request, Request} >> ptr;
    sum      = '0;
    GrantIdx = '0;
    Grant    = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        sum = {1'b0, ptr} + (IW + 1)'(j);
        if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
        GrantIdx = sum[IW-1:0];
      end
    end
    if (|Request) Grant = N'(1) << GrantIdx;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ptr <= '0;
    end else if (Advance && |Request) begin
      ptr <= (GrantIdx == IW'(N - 1)) ? '0 : GrantIdx + 1'b1;
    end
  end

endmodule

// File: rtl/uoram_multi_frontend.sv
// Multi-port ORAM frontend: arbitrates requests, walks the PosMap chain via PLB lookups,
// then issues backend commands deepest-first. Define UORAM_FAKE_PLB_MISS_EN to force misses.
module uoram_multi_frontend
  import uoram_pkg::*;
#(
  parameter int NumChannels   = 2,
  parameter int ORAMU         = 32,
  parameter int BECMDWidth    = 2,
  parameter int Recursion     = 3,
  parameter int LeafInBlock   = 16,
  parameter int NumValidBlock = 1024
) (
  input  logic                                Clock,
  input  logic                                Reset,
  input  logic [NumChannels-1:0]              CmdInValid,
  output logic [NumChannels-1:0]              CmdInReady,
  input  logic [NumChannels*BECMDWidth-1:0]   CmdIn,
  input  logic [NumChannels*ORAMU-1:0]        ProgAddrIn,
  output logic                                PLBReqValid,
  input  logic                                PLBReqReady,
  output logic [ORAMU-1:0]                    PLBReqAddr,
  input  logic                                PLBRespValid,
  input  logic                                PLBRespHit,
  output logic                                CmdOutValid,
  input  logic                                CmdOutReady,
  output logic [BECMDWidth-1:0]               CmdOut,
  output logic [ORAMU-1:0]                    AddrOut,
  output logic [idx_width(NumChannels)-1:0]   CmdOutChannel,
  output logic                                ErrValid,
  input  logic                                ErrReady,
  output logic [idx_width(NumChannels)-1:0]   ErrChannel,
  output logic [ORAMU-1:0]                    ErrAddr
);

  localparam int CW      = idx_width(NumChannels);
  localparam int DW      = idx_width(Recursion);
  localparam int LogLeaf = clog2(LeafInBlock);
  localparam logic [BECMDWidth-1:0] CmdRmv = BECMDWidth'(BECMD_ReadRmv);

  if (NumChannels < 1) begin : g_bad_channels
    $error("NumChannels must be at least 1");
  end
  if ((1 << LogLeaf) != LeafInBlock) begin : g_bad_leaf
    $error("LeafInBlock must be a power of 2");
  end
  if (64'(NumValidBlock) + 64'(NumValidBlock / LeafInBlock) * 64'(Recursion) >= (64'd1 << ORAMU))
  begin : g_bad_range
    $error("PosMap address space overflows ORAMU bits");
  end

  fe_state_t               state;
  logic [DW-1:0]           Depth;
  logic [ORAMU-1:0]        AddrQ [Recursion];
  logic [BECMDWidth-1:0]   cmd_q;
  logic [CW-1:0]           ch_q;

  logic [NumChannels-1:0]  arb_req;
  logic [NumChannels-1:0]  grant;
  logic [CW-1:0]           grant_idx;
  logic                    accept;
  logic [BECMDWidth-1:0]   sel_cmd;
  logic [ORAMU-1:0]        sel_addr;
  logic [ORAMU-1:0]        next_addr;
  logic [DW-1:0]           depth_inc;
  logic [DW-1:0]           depth_dec;
  logic                    resp_hit;

  // Reset gates the grant too, so CmdInReady is low while reset is asserted.
  assign arb_req    = CmdInValid & {NumChannels{(state == ST_IDLE) && !ErrValid && Reset}};
  assign CmdInReady = grant;
  assign accept     = |(CmdInValid & grant);
  assign sel_cmd    = CmdIn[int'(grant_idx) * BECMDWidth +: BECMDWidth];
  assign sel_addr   = ProgAddrIn[int'(grant_idx) * ORAMU +: ORAMU];
  assign depth_inc  = Depth + 1'b1;
  assign depth_dec  = Depth - 1'b1;
  assign next_addr  = ORAMU'(NumValidBlock) + (AddrQ[Depth] >> LogLeaf);

`ifdef UORAM_FAKE_PLB_MISS_EN
  assign resp_hit = (Depth == DW'(Recursion - 1));
`else
  assign resp_hit = PLBRespHit || (Depth == DW'(Recursion - 1));
`endif

  uoram_rr_arbiter #(.N(NumChannels)) u_arb (
    .Clock    (Clock),
    .Reset    (Reset),
    .Request  (arb_req),
    .Advance  (accept),
    .Grant    (grant),
    .GrantIdx (grant_idx)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state         <= ST_IDLE;
      Depth         <= '0;
      cmd_q         <= '0;
      ch_q          <= '0;
      PLBReqValid   <= 1'b0;
      PLBReqAddr    <= '0;
      CmdOutValid   <= 1'b0;
      CmdOut        <= '0;
      AddrOut       <= '0;
      CmdOutChannel <= '0;
      ErrValid      <= 1'b0;
      ErrChannel    <= '0;
      ErrAddr       <= '0;
      for (int i = 0; i < Recursion; i++) AddrQ[i] <= '0;
    end else begin
      if (ErrValid && ErrReady) begin
        ErrValid   <= 1'b0;
        ErrChannel <= '0;
        ErrAddr    <= '0;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cmd_q <= sel_cmd;
            ch_q  <= grant_idx;
            if (sel_addr >= ORAMU'(NumValidBlock)) begin
              ErrValid   <= 1'b1;
              ErrChannel <= grant_idx;
              ErrAddr    <= sel_addr;
            end else begin
              AddrQ[0]    <= sel_addr;
              Depth       <= '0;
              PLBReqValid <= 1'b1;
              PLBReqAddr  <= sel_addr;
              state       <= ST_LOOKUP;
            end
          end
        end
        ST_LOOKUP: begin
          if (PLBReqReady) begin
            PLBReqValid <= 1'b0;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (PLBRespValid) begin
            if (resp_hit) begin
              CmdOutValid   <= 1'b1;
              CmdOut        <= (Depth != '0) ? CmdRmv : cmd_q;
              AddrOut       <= AddrQ[Depth];
              CmdOutChannel <= ch_q;
              state         <= ST_ISSUE;
            end else begin
              AddrQ[depth_inc] <= next_addr;
              Depth            <= depth_inc;
              PLBReqValid      <= 1'b1;
              PLBReqAddr       <= next_addr;
              state            <= ST_LOOKUP;
            end
          end
        end
        ST_ISSUE: begin
          if (CmdOutReady) begin
            if (Depth != '0) begin
              Depth   <= depth_dec;
              CmdOut  <= (depth_dec != '0) ? CmdRmv : cmd_q;
              AddrOut <= AddrQ[depth_dec];
            end else begin
              CmdOutValid <= 1'b0;
              state       <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
